// File: rtl/bdc_tx_shifter.sv
// BDC transmit shifter: pops bytes from a FWFT tx FIFO and sends them MSB-first as pulse-width coded bits.
// Optional macro BDC_TX_SPEEDUP_EN adds a one-cycle active-high drive right after each low pulse.
module bdc_tx_shifter #(
  parameter int unsigned BIT_CYC  = 16,
  parameter int unsigned LOW_ONE  = 4,
  parameter int unsigned LOW_ZERO = 13,
  parameter int unsigned GAP_CYC  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       empty,
  input  logic [7:0] get_byte,
  output logic       get_pulse,
  output logic       bdc_oe,
  output logic       bdc_out,
  output logic       busy,
  output logic       byte_done
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] LEN_ONE  = CW'(LOW_ONE);
  localparam logic [CW-1:0] LEN_ZERO = CW'(LOW_ZERO);
  localparam logic [CW-1:0] MSB_IDX  = CW'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIT  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          get_pulse_q, get_pulse_d;
  logic          oe_q, oe_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start_c;
  logic          bit_end_c;
  logic          gap_end_c;
  logic [CW-1:0] low_len_c;

  assign start_c   = tx_en && !empty;
  assign bit_end_c = (cyc_q == BIT_LAST);
  assign gap_end_c = (cyc_q == GAP_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus shift register / counter updates
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    cyc_d       = cyc_q;
    get_pulse_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d     = S_BIT;
          shift_d     = get_byte;
          bit_d       = MSB_IDX;
          cyc_d       = '0;
          get_pulse_d = 1'b1;
        end
      end
      S_BIT: begin
        if (bit_end_c) begin
          cyc_d = '0;
          if (bit_q != '0) begin
            bit_d   = bit_q - CW'(1);
            shift_d = {shift_q[6:0], 1'b0};
          end else begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_end_c) begin
          state_d = S_IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pad and status outputs are decoded from next-state values so the registered pins line up with the bit cycle
  always_comb begin
    low_len_c = shift_d[7] ? LEN_ONE : LEN_ZERO;
    oe_d      = 1'b0;
    out_d     = 1'b1;
    busy_d    = (state_d != S_IDLE);
    if (state_d == S_BIT) begin
      if (cyc_d < low_len_c) begin
        oe_d  = 1'b1;
        out_d = 1'b0;
      end
`ifdef BDC_TX_SPEEDUP_EN
      else if (cyc_d == low_len_c) begin
        oe_d = 1'b1;
      end
`endif
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      bit_q       <= MSB_IDX;
      cyc_q       <= '0;
      get_pulse_q <= 1'b0;
      oe_q        <= 1'b0;
      out_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cyc_q       <= cyc_d;
      get_pulse_q <= get_pulse_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign get_pulse = get_pulse_q;
  assign bdc_oe    = oe_q;
  assign bdc_out   = out_q;
  assign busy      = busy_q;
  assign byte_done = done_q;

endmodule

// File: tb/tb_bdc_tx_shifter.sv
// Testbench for bdc_tx_shifter: FIFO model plus per-bit pulse-width reference derived from byte values.
// Expectations follow BDC_TX_SPEEDUP_EN when defined.
module tb_bdc_tx_shifter;

  localparam int BIT_CYC  = 16;
  localparam int LOW_ONE  = 4;
  localparam int LOW_ZERO = 13;
  localparam int GAP_CYC  = 16;
  localparam int BYTE_CYC = 8 * BIT_CYC;
  localparam int SPACING  = BYTE_CYC + GAP_CYC + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       empty;
  logic [7:0] get_byte;
  logic       get_pulse;
  logic       bdc_oe;
  logic       bdc_out;
  logic       busy;
  logic       byte_done;

  int total = 0;
  int bad   = 0;
  logic [7:0] fifo[$];

  always #5 clk = ~clk;

  bdc_tx_shifter #(
    .BIT_CYC (BIT_CYC),
    .LOW_ONE (LOW_ONE),
    .LOW_ZERO(LOW_ZERO),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .empty    (empty),
    .get_byte (get_byte),
    .get_pulse(get_pulse),
    .bdc_oe   (bdc_oe),
    .bdc_out  (bdc_out),
    .busy     (busy),
    .byte_done(byte_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fifo();
    empty    = (fifo.size() == 0);
    get_byte = empty ? 8'($urandom) : fifo[0];
  endtask

  // Expected drive-enable pattern over one bit period
  function automatic logic [15:0] exp_oe(input logic b);
    logic [15:0] v;
    int l;
    l = b ? LOW_ONE : LOW_ZERO;
    v = '0;
    for (int c = 0; c < BIT_CYC; c++) begin
      v[c] = (c < l);
`ifdef BDC_TX_SPEEDUP_EN
      if (c == l) v[c] = 1'b1;
`endif
    end
    return v;
  endfunction

  function automatic logic [15:0] exp_out(input logic b);
    logic [15:0] v;
    int l;
    l = b ? LOW_ONE : LOW_ZERO;
    v = '0;
    for (int c = 0; c < BIT_CYC; c++) v[c] = (c >= l);
    return v;
  endfunction

  task automatic wait_pop(input int max_cyc, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b0;
    while (waited < max_cyc) begin
      if (get_pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
      waited++;
    end
  endtask

  // Entered on the cycle get_pulse is high; returns on the first idle cycle after the gap
  task automatic check_byte(input logic [7:0] b, input int drop_at, input string tag);
    logic [15:0] oe_v, out_v;
    int gp, bd, bd_t, busy_lo, gap_drv, bi, c;
    gp = 0; bd = 0; bd_t = -1; busy_lo = 0; gap_drv = 0;
    oe_v = '0; out_v = '0;
    for (int t = 0; t < BYTE_CYC + GAP_CYC; t++) begin
      if (t == drop_at) tx_en = 1'b0;
      if (get_pulse === 1'b1) begin
        gp++;
        if (fifo.size() > 0) fifo.delete(0);
        drive_fifo();
      end
      if (byte_done === 1'b1) begin
        bd++;
        bd_t = t;
      end
      if (busy !== 1'b1) busy_lo++;
      if (t < BYTE_CYC) begin
        c = t % BIT_CYC;
        oe_v[c]  = bdc_oe;
        out_v[c] = bdc_out;
        if (c == BIT_CYC - 1) begin
          bi = 7 - t / BIT_CYC;
          total++;
          if (oe_v !== exp_oe(b[bi]) || out_v !== exp_out(b[bi])) begin
            bad++;
            $display("FAIL %s byte %h bit%0d: oe=%h out=%h required oe=%h out=%h",
                     tag, b, bi, oe_v, out_v, exp_oe(b[bi]), exp_out(b[bi]));
          end
        end
      end else if (bdc_oe !== 1'b0 || bdc_out !== 1'b1) begin
        gap_drv++;
      end
      step();
    end
    total++;
    if (gp !== 1) begin
      bad++;
      $display("FAIL %s pop_count: got %0d required 1", tag, gp);
    end
    total++;
    if (bd !== 1 || bd_t !== BYTE_CYC) begin
      bad++;
      $display("FAIL %s byte_done: count %0d at t=%0d required 1 at t=%0d", tag, bd, bd_t, BYTE_CYC);
    end
    total++;
    if (busy_lo !== 0 || gap_drv !== 0) begin
      bad++;
      $display("FAIL %s busy/gap: busy_low=%0d gap_drive=%0d required 0 0", tag, busy_lo, gap_drv);
    end
    total++;
    if (busy !== 1'b0 || bdc_oe !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after_gap: busy=%b oe=%b required 0 0", tag, busy, bdc_oe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_en = 1'b0;
    fifo.delete();
    drive_fifo();
    #3;
    total++;
    if ({get_pulse, bdc_oe, bdc_out, busy, byte_done} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 00100",
               {get_pulse, bdc_oe, bdc_out, busy, byte_done});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_empty_idle();
    int gp, oe, bz;
    gp = 0; oe = 0; bz = 0;
    tx_en = 1'b1;
    drive_fifo();
    repeat (100) begin
      step();
      if (get_pulse !== 1'b0) gp++;
      if (bdc_oe !== 1'b0) oe++;
      if (busy !== 1'b0) bz++;
    end
    total++;
    if (gp !== 0) begin bad++; $display("FAIL empty_pop: got %0d pops required 0", gp); end
    total++;
    if (oe !== 0) begin bad++; $display("FAIL empty_oe: got %0d drive cycles required 0", oe); end
    total++;
    if (bz !== 0) begin bad++; $display("FAIL empty_busy: got %0d busy cycles required 0", bz); end
  endtask

  task automatic test_single_a5();
    bit ok;
    fifo.push_back(8'hA5);
    drive_fifo();
    tx_en = 1'b1;
    wait_pop(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL a5_pop: got no pop required pop within 10 cycles"); end
    check_byte(8'hA5, -1, "a5");
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] b;
    fifo.push_back(8'hFF);
    fifo.push_back(8'h00);
    fifo.push_back(8'h80);
    drive_fifo();
    tx_en = 1'b1;
    wait_pop(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_first_pop: got no pop required pop"); end
    for (int i = 0; i < 3; i++) begin
      b = fifo[0];
      check_byte(b, -1, "b2b");
      if (i < 2) begin
        step();
        total++;
        if (get_pulse !== 1'b1) begin
          bad++;
          $display("FAIL b2b_spacing: get_pulse=%b at %0d cycles required 1", get_pulse, SPACING);
        end
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    bit ok;
    fifo.push_back(8'h3C);
    drive_fifo();
    tx_en = 1'b1;
    wait_pop(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_mid_pop: got no pop required pop"); end
    fifo.delete(0);
    drive_fifo();
    // bit 3 is the fifth period; cycle 1 of it is still in the low phase
    repeat (4 * BIT_CYC + 1) step();
    total++;
    if (bdc_oe !== 1'b1 || bdc_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_low: oe=%b out=%b required 1 0", bdc_oe, bdc_out);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bdc_oe, bdc_out, busy, get_pulse} !== 4'b0100) begin
      bad++;
      $display("FAIL rst_mid_release: oe/out/busy/pop=%b required 0100",
               {bdc_oe, bdc_out, busy, get_pulse});
    end
    step();
    reset = 1'b0;
    fifo.push_back(8'h5A);
    drive_fifo();
    wait_pop(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_mid_fresh_pop: got no pop required pop"); end
    check_byte(8'h5A, -1, "after_rst");
  endtask

  task automatic test_tx_en();
    int gp;
    logic [7:0] b;
    gp = 0;
    tx_en = 1'b0;
    fifo.push_back(8'($urandom));
    drive_fifo();
    repeat (30) begin
      step();
      if (get_pulse !== 1'b0) gp++;
    end
    total++;
    if (gp !== 0) begin bad++; $display("FAIL txen_hold: got %0d pops required 0", gp); end
    tx_en = 1'b1;
    step();
    total++;
    if (get_pulse !== 1'b1) begin
      bad++;
      $display("FAIL txen_start: get_pulse=%b required 1", get_pulse);
    end
    b = fifo[0];
    check_byte(b, 20, "txen_drop");
    tx_en = 1'b1;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    int drop;
    for (int i = 0; i < 8; i++) begin
      tx_en = 1'b0;
      fifo.push_back(8'($urandom));
      drive_fifo();
      repeat ($urandom_range(0, 5)) step();
      tx_en = 1'b1;
      wait_pop(20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand_pop %0d: got no pop required pop", i); end
      b = fifo[0];
      drop = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, BYTE_CYC - 1));
      check_byte(b, drop, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_empty_idle();
    test_single_a5();
    test_back_to_back();
    test_reset_mid_byte();
    test_tx_en();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
